// File: rtl/pirdsp_acc_pkg.sv
// Shared types, widths and the lane extension helper for the c1x2 accumulator.
package pirdsp_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  localparam int unsigned PROD_W      = 24;
  localparam int unsigned HALF_PROD_W = 12;
  localparam int unsigned EXT_MAX_W   = 64;
  localparam int unsigned IDX_W       = $clog2(PROD_W);

  // Extend the low src_w bits of v to EXT_MAX_W; callers size-cast to the width they need.
  function automatic logic [EXT_MAX_W-1:0] extend(input logic [PROD_W-1:0] v,
                                                  input int unsigned      src_w,
                                                  input logic             sgn);
    logic [EXT_MAX_W-1:0] keep;
    logic                 fill;
    keep = ~({EXT_MAX_W{1'b1}} << src_w);
    fill = sgn & v[IDX_W'(src_w - 1)];
    return (EXT_MAX_W'(v) & keep) | ({EXT_MAX_W{fill}} & ~keep);
  endfunction

endpackage

// File: rtl/pirdsp_c1x2_accumulator_if.sv
// Beat input / result output bundle of the c1x2 accumulator.
// out_sat exists only when ACC_SATURATE_EN is defined.
interface pirdsp_c1x2_accumulator_if #(
  parameter int unsigned ACC_W = 48,
  parameter int unsigned CNT_W = 16
);
  import pirdsp_acc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] C;
  logic              prod_sign;
  logic              HALF_0;
  logic              HALF_1;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_cnt;
  logic              out_half;
  logic              err_mode;
`ifdef ACC_SATURATE_EN
  logic              out_sat;
`endif

  modport master (
    output in_valid, C, prod_sign, HALF_0, HALF_1, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_cnt, out_half, err_mode
`ifdef ACC_SATURATE_EN
    , input out_sat
`endif
  );

  modport slave (
    input  in_valid, C, prod_sign, HALF_0, HALF_1, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_cnt, out_half, err_mode
`ifdef ACC_SATURATE_EN
    , output out_sat
`endif
  );

endinterface

// File: rtl/pirdsp_acc_lane.sv
// One accumulator lane: add (or load) an extended operand with carry-in, optional clamp.
// Clamp logic and its ports exist only when ACC_SATURATE_EN is defined.
module pirdsp_acc_lane #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         add,
  input  logic         cin,
  input  logic [W-1:0] op,
`ifdef ACC_SATURATE_EN
  input  logic         is_signed,
  input  logic         part_lo,    // lower half of a chained word: clamps to all-ones / zero
  input  logic         sat_force,
  input  logic         sat_pos,
  output logic         ovf,
  output logic         ovf_pos,
`endif
  output logic         cout,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_q;
  logic [W-1:0] base;
  logic [W:0]   sum;
  logic [W-1:0] acc_d;

  // A load restarts the lane from zero so the same adder serves both paths.
  assign base = load ? '0 : acc_q;
  assign sum  = {1'b0, base} + {1'b0, op} + {{W{1'b0}}, cin};
  assign cout = sum[W];
  assign acc  = acc_q;

`ifdef ACC_SATURATE_EN
  logic [W-1:0] clamp;

  assign ovf     = is_signed ? ((base[W-1] == op[W-1]) && (sum[W-1] != base[W-1])) : sum[W];
  assign ovf_pos = is_signed ? ~base[W-1] : 1'b1;

  // Select the bound this lane snaps to when an overflow is flagged for the word.
  always_comb begin
    clamp = '0;
    if (part_lo) begin
      clamp = sat_pos ? '1 : '0;
    end else if (!is_signed) begin
      clamp = '1;
    end else begin
      clamp = sat_pos ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
    end
  end

  assign acc_d = sat_force ? clamp : sum[W-1:0];
`else
  assign acc_d = sum[W-1:0];
`endif

  // Lane register, written only on accepted good beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (load || add) begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pirdsp_c1x2_accumulator.sv
// Batch accumulator behind the 16x8 / dual-8x4 multiplier: one 48-bit lane in full mode,
// two independent ACC_W/2 lanes in half mode, result held in DRAIN until accepted.
// Optional feature macro: ACC_SATURATE_EN (clamping lanes plus sticky out_sat).
module pirdsp_c1x2_accumulator
  import pirdsp_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 48,
  parameter int unsigned CNT_W = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  pirdsp_c1x2_accumulator_if.slave bus
);

  localparam int unsigned LW = ACC_W / 2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic             sign_q, sign_d;
  logic             err_q, err_d;

  logic             accept, reject, beat_ok, load, add;
  logic [ACC_W-1:0] ext_full;
  logic [LW-1:0]    ext_hi, ext_lo, op_hi, op_lo, acc_hi, acc_lo;
  logic             lo_cout, hi_cout, hi_cin;

  assign accept = bus.in_valid && (state_q != DRAIN);
  // Mode must be one-hot, and inside a batch must match what the first beat latched.
  assign reject = (bus.HALF_0 == bus.HALF_1) ||
                  ((state_q == ACCUM) && ((bus.HALF_1 != half_q) || (bus.prod_sign != sign_q)));
  assign beat_ok = accept && !reject;
  assign load    = beat_ok && (state_q == IDLE);
  assign add     = beat_ok && (state_q == ACCUM);

  assign ext_full = ACC_W'(extend(bus.C, PROD_W, bus.prod_sign));
  assign ext_hi   = LW'(extend({{HALF_PROD_W{1'b0}}, bus.C[PROD_W-1:HALF_PROD_W]},
                               HALF_PROD_W, bus.prod_sign));
  assign ext_lo   = LW'(extend({{HALF_PROD_W{1'b0}}, bus.C[HALF_PROD_W-1:0]},
                               HALF_PROD_W, bus.prod_sign));
  assign op_hi    = bus.HALF_1 ? ext_hi : ext_full[ACC_W-1:LW];
  assign op_lo    = bus.HALF_1 ? ext_lo : ext_full[LW-1:0];
  // Half mode breaks the carry chain so the lanes stay independent.
  assign hi_cin   = bus.HALF_1 ? 1'b0 : lo_cout;

`ifdef ACC_SATURATE_EN
  logic lo_ovf, lo_pos, hi_ovf, hi_pos, lo_force, lo_dir, sat_q;

  // In full mode the upper lane owns the overflow decision for the whole word.
  assign lo_force = bus.HALF_1 ? lo_ovf : hi_ovf;
  assign lo_dir   = bus.HALF_1 ? lo_pos : hi_pos;
`endif

  pirdsp_acc_lane #(.W(LW)) u_lane_lo (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .add       (add),
    .cin       (1'b0),
    .op        (op_lo),
`ifdef ACC_SATURATE_EN
    .is_signed (bus.prod_sign),
    .part_lo   (~bus.HALF_1),
    .sat_force (lo_force),
    .sat_pos   (lo_dir),
    .ovf       (lo_ovf),
    .ovf_pos   (lo_pos),
`endif
    .cout      (lo_cout),
    .acc       (acc_lo)
  );

  pirdsp_acc_lane #(.W(LW)) u_lane_hi (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .add       (add),
    .cin       (hi_cin),
    .op        (op_hi),
`ifdef ACC_SATURATE_EN
    .is_signed (bus.prod_sign),
    .part_lo   (1'b0),
    .sat_force (hi_ovf),
    .sat_pos   (hi_pos),
    .ovf       (hi_ovf),
    .ovf_pos   (hi_pos),
`endif
    .cout      (hi_cout),
    .acc       (acc_hi)
  );

  // Next state and batch bookkeeping (mode latch, saturating beat count, error pulse).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    sign_d  = sign_q;
    err_d   = accept && reject;
    unique case (state_q)
      IDLE: begin
        if (beat_ok) begin
          half_d  = bus.HALF_1;
          sign_d  = bus.prod_sign;
          cnt_d   = CNT_W'(1);
          state_d = bus.in_last ? DRAIN : ACCUM;
        end
      end
      ACCUM: begin
        if (add && (cnt_q != {CNT_W{1'b1}})) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // A rejected last beat still closes the batch.
        if (accept && bus.in_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      half_q  <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      sign_q  <= sign_d;
      err_q   <= err_d;
    end
  end

`ifdef ACC_SATURATE_EN
  // Sticky clamp flag for the current batch, cleared as the result is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if ((state_q == DRAIN) && bus.out_ready) begin
      sat_q <= 1'b0;
    end else if ((load || add) && (lo_force || hi_ovf)) begin
      sat_q <= 1'b1;
    end
  end

  assign bus.out_sat = sat_q;
`endif

  assign bus.in_ready  = (state_q != DRAIN);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_acc   = {acc_hi, acc_lo};
  assign bus.out_cnt   = cnt_q;
  assign bus.out_half  = half_q;
  assign bus.err_mode  = err_q;

endmodule

// File: tb/tb_pirdsp_c1x2_accumulator.sv
// Scoreboard bench for pirdsp_c1x2_accumulator (default build, ACC_W=48, CNT_W=16).
module tb_pirdsp_c1x2_accumulator;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   err_seen;

  typedef struct {
    logic [47:0] acc;
    logic [15:0] cnt;
    logic        half;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;

  pirdsp_c1x2_accumulator_if #(.ACC_W(48), .CNT_W(16)) bus ();

  pirdsp_c1x2_accumulator #(.ACC_W(48), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Monitor: compare each handed-off result against the oldest expectation.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got acc %h with no expected result", bus.out_acc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_acc", 64'(bus.out_acc), 64'(mon_e.acc));
        chk("out_cnt", 64'(bus.out_cnt), 64'(mon_e.cnt));
        chk("out_half", 64'(bus.out_half), 64'(mon_e.half));
      end
    end
  end

  // Count cycles with err_mode high; a one-cycle pulse per rejected beat is expected.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && bus.err_mode) err_seen++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_res(input logic [47:0] acc, input logic [15:0] cnt, input logic half);
    res_t r;
    r.acc  = acc;
    r.cnt  = cnt;
    r.half = half;
    exp_q.push_back(r);
  endtask

  task automatic send(input logic [23:0] c, input logic sgn, input logic h0, input logic h1,
                      input logic last);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.C         = c;
    bus.prod_sign = sgn;
    bus.HALF_0    = h0;
    bus.HALF_1    = h1;
    bus.in_last   = last;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending got %0d expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    err_seen      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.C         = '0;
    bus.prod_sign = 1'b0;
    bus.HALF_0    = 1'b1;
    bus.HALF_1    = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_acc", 64'(bus.out_acc), 64'd0);
    chk("rst_out_cnt", 64'(bus.out_cnt), 64'd0);
    chk("rst_out_half", 64'(bus.out_half), 64'd0);
    chk("rst_err_mode", 64'(bus.err_mode), 64'd0);

    // Full unsigned, four beats.
    expect_res(48'h3FFFC, 16'd4, 1'b0);
    for (int i = 0; i < 4; i++) send(24'h00FFFF, 1'b0, 1'b1, 1'b0, i == 3);
    wait_drain();

    // Full signed: -1 + 5.
    expect_res(48'd4, 16'd2, 1'b0);
    send(24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    send(24'h000005, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Full signed: -1 + -1 needs the carry chain across the lane boundary.
    expect_res(48'hFFFF_FFFF_FFFE, 16'd2, 1'b0);
    send(24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    send(24'hFFFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Half signed: hi -1 x3, lo 3 x3.
    expect_res({24'hFFFFFD, 24'h000009}, 16'd3, 1'b1);
    for (int i = 0; i < 3; i++) send(24'hFFF003, 1'b1, 1'b0, 1'b1, i == 2);
    wait_drain();

    // Half signed: lo lane goes negative, nothing may leak into hi.
    expect_res({24'h000002, 24'hFFFFFE}, 16'd2, 1'b1);
    send(24'h001FFF, 1'b1, 1'b0, 1'b1, 1'b0);
    send(24'h001FFF, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // Backpressure: result held, beats offered during DRAIN ignored.
    bus.out_ready = 1'b0;
    expect_res(48'd30, 16'd2, 1'b0);
    send(24'd10, 1'b0, 1'b1, 1'b0, 1'b0);
    send(24'd20, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.C        = 24'h123456;
      bus.HALF_0   = 1'b1;
      bus.HALF_1   = 1'b0;
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_acc", 64'(bus.out_acc), 64'd30);
      chk("bp_out_cnt", 64'(bus.out_cnt), 64'd2);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 64'(bus.out_valid), 64'd0);
    chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
    wait_drain();

    // Mode errors inside a full unsigned batch: bad mode, sign change, mode change.
    expect_res(48'd101, 16'd2, 1'b0);
    send(24'd100, 1'b0, 1'b1, 1'b0, 1'b0);
    send(24'd55, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("err_pulse", 64'(bus.err_mode), 64'd1);
    send(24'd55, 1'b1, 1'b1, 1'b0, 1'b0);
    send(24'd55, 1'b0, 1'b0, 1'b1, 1'b0);
    send(24'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // A rejected last beat still closes the batch.
    expect_res(48'd3, 16'd1, 1'b0);
    send(24'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    send(24'd9, 1'b0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // A rejected first beat leaves the block idle even with in_last.
    send(24'd9, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("idle_rej_valid", 64'(bus.out_valid), 64'd0);
    chk("idle_rej_ready", 64'(bus.in_ready), 64'd1);
    expect_res(48'd7, 16'd1, 1'b0);
    send(24'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Reset in the middle of a batch discards it.
    send(24'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    send(24'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_cnt", 64'(bus.out_cnt), 64'd0);
    chk("mid_rst_acc", 64'(bus.out_acc), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_res(48'd7, 16'd1, 1'b0);
    send(24'd7, 1'b0, 1'b1, 1'b0, 1'b1);
    wait_drain();

    // Reset while a result is waiting drops out_valid without a clock.
    bus.out_ready = 1'b0;
    send(24'd9, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("drain_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("drain_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("drain_rst_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);

    // Beat counter saturates at 16'hFFFF while the sum keeps going.
    expect_res(48'h10001, 16'hFFFF, 1'b0);
    for (int i = 0; i < 65537; i++) send(24'd1, 1'b0, 1'b1, 1'b0, i == 65536);
    wait_drain();

    chk("err_pulses", 64'(err_seen), 64'd5);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
